// File: rtl/spi_byte_pkg.sv
// Shared types and constants for the single-byte SPI master.
package spi_byte_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } state_t;

  localparam int unsigned BITS            = 8;
  localparam int unsigned HALF_PERIODS    = 2 * BITS;
  localparam int unsigned DEFAULT_CLK_DIV = 4;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: half-period tick, leading/trailing edge strobes and the SCLK register.
module spi_sclk_gen
  import spi_byte_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
  parameter logic        CPOL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic toggle_en,
  output logic tick_c,
  output logic lead_c,
  output logic trail_c,
  output logic sclk
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  // A tick closes every CLK_DIV-cycle slot; the counter restarts whenever the FSM idles.
  assign tick_c  = run && (cnt == CNT_W'(CLK_DIV - 1));
  assign lead_c  = tick_c && toggle_en && (sclk == CPOL);
  assign trail_c = tick_c && toggle_en && (sclk != CPOL);

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt  <= '0;
      sclk <= CPOL;
    end else begin
      cnt <= tick_c ? '0 : cnt + CNT_W'(1);
      if (tick_c && toggle_en) sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_byte_master.sv
// Single-byte SPI master: one start shifts a byte out MSB first and captures one byte in.
module spi_byte_master
  import spi_byte_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
  parameter logic        CPOL    = 1'b0,
  parameter logic        CPHA    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       done,
  output logic [7:0] data_out,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  localparam int unsigned HCNT_W = $clog2(HALF_PERIODS + 1);

  state_t            state;
  logic [BITS-1:0]   tx_sh;
  logic [BITS-1:0]   rx_sh;
  logic [HCNT_W-1:0] hcnt;

  logic run_c;
  logic toggle_en_c;
  logic tick_c;
  logic lead_c;
  logic trail_c;
  logic sample_c;
  logic shift_c;

  assign run_c       = (state != IDLE);
  assign toggle_en_c = (state == SETUP) ||
                       ((state == XFER) && (hcnt != HCNT_W'(HALF_PERIODS)));
  assign sample_c    = CPHA ? trail_c : lead_c;
  assign shift_c     = CPHA ? lead_c  : trail_c;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .run       (run_c),
    .toggle_en (toggle_en_c),
    .tick_c    (tick_c),
    .lead_c    (lead_c),
    .trail_c   (trail_c),
    .sclk      (sclk)
  );

  // In mode CPHA=0 bit 7 goes out with cs_n, so tx_sh is preloaded already shifted;
  // every later shift edge then presents tx_sh[MSB] in both phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      hcnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SETUP;
            cs_n  <= 1'b0;
            rx_sh <= '0;
            hcnt  <= '0;
            tx_sh <= CPHA ? data_in : {data_in[BITS-2:0], 1'b0};
            mosi  <= CPHA ? 1'b0 : data_in[BITS-1];
          end
        end
        SETUP: begin
          if (tick_c) begin
            state <= XFER;
            hcnt  <= HCNT_W'(1);
          end
        end
        XFER: begin
          if (tick_c) begin
            if (hcnt == HCNT_W'(HALF_PERIODS)) state <= HOLD;
            else hcnt <= hcnt + HCNT_W'(1);
          end
        end
        HOLD: begin
          if (tick_c) begin
            state    <= IDLE;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            done     <= 1'b1;
            data_out <= rx_sh;
            hcnt     <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      if (sample_c) rx_sh <= {rx_sh[BITS-2:0], miso};
      if (shift_c) begin
        mosi  <= tx_sh[BITS-1];
        tx_sh <= {tx_sh[BITS-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: one instance per SPI mode, each with a behavioural slave.
module tb_spi_byte_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loopback = 1'b1;
  logic [3:0] start = '0;
  logic [3:0][7:0] data_in = '0;
  logic [3:0][7:0] s_load = '0;
  logic [3:0] miso, sclk, mosi, cs_n, done;
  logic [3:0][7:0] data_out, s_got;
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_m
    localparam logic POL = 1'((g >> 1) & 1);
    localparam logic PHA = 1'(g & 1);
    logic s_miso = 1'b0;
    logic [7:0] s_tx = '0;
    logic [7:0] s_rx = '0;
    logic p_cs = 1'b1;
    logic p_sclk = POL;

    spi_byte_master #(.CLK_DIV(4), .CPOL(POL), .CPHA(PHA)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start[g]),
      .data_in  (data_in[g]),
      .done     (done[g]),
      .data_out (data_out[g]),
      .sclk     (sclk[g]),
      .mosi     (mosi[g]),
      .miso     (miso[g]),
      .cs_n     (cs_n[g])
    );

    assign miso[g]  = loopback ? mosi[g] : s_miso;
    assign s_got[g] = s_rx;

    // Slave: loads its reply on cs_n fall, samples/shifts on the SCLK edges of its mode.
    always @(sclk[g] or cs_n[g]) begin
      if (p_cs == 1'b1 && cs_n[g] == 1'b0) begin
        s_tx = s_load[g];
        s_rx = 8'h00;
        s_miso = PHA ? 1'b0 : s_tx[7];
      end else if (cs_n[g] == 1'b0 && sclk[g] != p_sclk) begin
        if ((sclk[g] != POL) ^ PHA) begin
          s_rx = {s_rx[6:0], mosi[g]};
        end else if (PHA) begin
          s_miso = s_tx[7];
          s_tx = {s_tx[6:0], 1'b0};
        end else begin
          s_tx = {s_tx[6:0], 1'b0};
          s_miso = s_tx[7];
        end
      end
      p_cs = cs_n[g];
      p_sclk = sclk[g];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive start just after edge T0; returns positioned just after edge T0+1.
  task automatic go(input int m, input logic [7:0] b);
    data_in[m] = b;
    start[m] = 1'b1;
    tick(1);
    start[m] = 1'b0;
  endtask

  // Called at T0+1; returns the edge offset (from T0) at which done was seen.
  task automatic wait_done(input int m, output int lat);
    lat = 1;
    while (done[m] !== 1'b1 && lat < 200) begin
      tick(1);
      lat++;
    end
  endtask

  task automatic test_reset();
    int lat;
    logic pol;
    rst = 1'b1;
    tick(10);
    for (int m = 0; m < 4; m++) begin
      pol = 1'((m >> 1) & 1);
      total++; if (cs_n[m] !== 1'b1) $display("FAIL reset_cs_n[%0d]: got %b want 1", m, cs_n[m]); else passed++;
      total++; if (sclk[m] !== pol) $display("FAIL reset_sclk[%0d]: got %b want %b", m, sclk[m], pol); else passed++;
    end
    total++; if (mosi[0] !== 1'b0) $display("FAIL reset_mosi: got %b want 0", mosi[0]); else passed++;
    total++; if (done[0] !== 1'b0) $display("FAIL reset_done: got %b want 0", done[0]); else passed++;
    total++; if (data_out[0] !== 8'h00) $display("FAIL reset_data_out: got %h want 00", data_out[0]); else passed++;
    rst = 1'b0;
    tick(2);
    loopback = 1'b1;
    go(0, 8'h5A);
    wait_done(0, lat);
    total++; if (lat != 73) $display("FAIL post_reset_latency: got %0d want 73", lat); else passed++;
    total++; if (data_out[0] !== 8'h5A) $display("FAIL post_reset_data: got %h want 5a", data_out[0]); else passed++;
    tick(2);
  endtask

  task automatic test_loopback_mode0();
    logic [7:0] exp_b;
    exp_b = 8'hA5;
    loopback = 1'b1;
    go(0, exp_b);
    total++; if (cs_n[0] !== 1'b0) $display("FAIL lb_cs_fall: got %b want 0", cs_n[0]); else passed++;
    total++; if (mosi[0] !== 1'b1) $display("FAIL lb_first_bit: got %b want 1", mosi[0]); else passed++;
    tick(3);
    total++; if (sclk[0] !== 1'b0) $display("FAIL lb_sclk_t4: got %b want 0", sclk[0]); else passed++;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      total++; if (sclk[0] !== 1'b1) $display("FAIL lb_rise%0d_sclk: got %b want 1", i, sclk[0]); else passed++;
      total++; if (mosi[0] !== exp_b[7-i]) $display("FAIL lb_rise%0d_mosi: got %b want %b", i, mosi[0], exp_b[7-i]); else passed++;
      if (i < 7) tick(8);
    end
    tick(11);
    total++; if (done[0] !== 1'b0 || cs_n[0] !== 1'b0) $display("FAIL lb_t72: got done=%b cs_n=%b want 0/0", done[0], cs_n[0]); else passed++;
    tick(1);
    total++; if (done[0] !== 1'b1 || cs_n[0] !== 1'b1) $display("FAIL lb_t73: got done=%b cs_n=%b want 1/1", done[0], cs_n[0]); else passed++;
    total++; if (data_out[0] !== 8'hA5) $display("FAIL lb_data_out: got %h want a5", data_out[0]); else passed++;
    tick(1);
    total++; if (done[0] !== 1'b0) $display("FAIL lb_done_width: got %b want 0", done[0]); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [5] = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00};
    int lat;
    loopback = 1'b0;
    s_load[0] = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      go(0, seq[i]);
      total++; if (cs_n[0] !== 1'b0) $display("FAIL b2b%0d_cs_low: got %b want 0", i, cs_n[0]); else passed++;
      wait_done(0, lat);
      total++; if (lat != 73) $display("FAIL b2b%0d_latency: got %0d want 73", i, lat); else passed++;
      total++; if (cs_n[0] !== 1'b1) $display("FAIL b2b%0d_cs_high: got %b want 1", i, cs_n[0]); else passed++;
      total++; if (s_got[0] !== seq[i]) $display("FAIL b2b%0d_slave_rx: got %h want %h", i, s_got[0], seq[i]); else passed++;
      total++; if (data_out[0] !== 8'h3C) $display("FAIL b2b%0d_data_out: got %h want 3c", i, data_out[0]); else passed++;
    end
    tick(3);
  endtask

  task automatic test_busy();
    int nd;
    int first;
    nd = 0;
    first = 0;
    loopback = 1'b0;
    s_load[0] = 8'h66;
    go(0, 8'hFF);
    tick(19);
    data_in[0] = 8'h00;
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    for (int k = 22; k <= 100; k++) begin
      tick(1);
      if (done[0] === 1'b1) begin
        nd++;
        if (first == 0) first = k;
      end
    end
    total++; if (nd != 1) $display("FAIL busy_done_count: got %0d want 1", nd); else passed++;
    total++; if (first != 73) $display("FAIL busy_done_time: got %0d want 73", first); else passed++;
    total++; if (s_got[0] !== 8'hFF) $display("FAIL busy_slave_rx: got %h want ff", s_got[0]); else passed++;
    total++; if (data_out[0] !== 8'h66) $display("FAIL busy_data_hold: got %h want 66", data_out[0]); else passed++;
  endtask

  task automatic test_reset_mid();
    int nd;
    int lat;
    nd = 0;
    loopback = 1'b0;
    s_load[0] = 8'h99;
    go(0, 8'hE7);
    tick(29);
    total++; if (sclk[0] !== 1'b1) $display("FAIL mid_sclk_t30: got %b want 1", sclk[0]); else passed++;
    rst = 1'b1;
    tick(1);
    total++; if (cs_n[0] !== 1'b1) $display("FAIL mid_cs_n: got %b want 1", cs_n[0]); else passed++;
    total++; if (sclk[0] !== 1'b0) $display("FAIL mid_sclk: got %b want 0", sclk[0]); else passed++;
    total++; if (mosi[0] !== 1'b0) $display("FAIL mid_mosi: got %b want 0", mosi[0]); else passed++;
    total++; if (data_out[0] !== 8'h00) $display("FAIL mid_data_out: got %h want 00", data_out[0]); else passed++;
    rst = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (done[0] === 1'b1) nd++;
      tick(1);
    end
    total++; if (nd != 0) $display("FAIL mid_no_done: got %0d want 0", nd); else passed++;
    s_load[0] = 8'h24;
    go(0, 8'h81);
    wait_done(0, lat);
    total++; if (lat != 73) $display("FAIL mid_next_latency: got %0d want 73", lat); else passed++;
    total++; if (data_out[0] !== 8'h24) $display("FAIL mid_next_data: got %h want 24", data_out[0]); else passed++;
    total++; if (s_got[0] !== 8'h81) $display("FAIL mid_next_slave_rx: got %h want 81", s_got[0]); else passed++;
    tick(2);
  endtask

  task automatic test_modes();
    int lat;
    logic pol;
    loopback = 1'b0;
    for (int m = 1; m < 4; m++) begin
      pol = 1'((m >> 1) & 1);
      s_load[m] = 8'hC3;
      total++; if (sclk[m] !== pol) $display("FAIL mode%0d_idle_sclk: got %b want %b", m, sclk[m], pol); else passed++;
      go(m, 8'h96);
      total++; if (cs_n[m] !== 1'b0 || sclk[m] !== pol) $display("FAIL mode%0d_t1: got cs_n=%b sclk=%b want 0/%b", m, cs_n[m], sclk[m], pol); else passed++;
      wait_done(m, lat);
      total++; if (lat != 73) $display("FAIL mode%0d_latency: got %0d want 73", m, lat); else passed++;
      total++; if (s_got[m] !== 8'h96) $display("FAIL mode%0d_slave_rx: got %h want 96", m, s_got[m]); else passed++;
      total++; if (data_out[m] !== 8'hC3) $display("FAIL mode%0d_data_out: got %h want c3", m, data_out[m]); else passed++;
      total++; if (sclk[m] !== pol) $display("FAIL mode%0d_end_sclk: got %b want %b", m, sclk[m], pol); else passed++;
      tick(2);
    end
  endtask

  initial begin
    test_reset();
    test_loopback_mode0();
    test_back_to_back();
    test_busy();
    test_reset_mid();
    test_modes();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
